junction_phase_scheduler: RTL and testbench

Demand-actuated phase scheduler for the 3-way junction. It latches per-approach vehicle requests and grants green to one of three conflicting phases, using round-robin order that skips phases with no demand. It enforces min/max green, gap extension, amber and all-red clearance. It drives a per-phase aspect bus that the lamp decoder expands to the R/A/G lamp outputs.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/tick_gen.sv | 27 ++
 rtl/junction_phase_scheduler.sv | 126 ++++++++++++
 tb/tb_junction_phase_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the junction phase controllers.
package traffic_pkg;

    localparam int unsigned NPHASE = 3;

    typedef logic [1:0] phase_t;

    typedef enum logic [1:0] {
        SS_ALL_RED,
        SS_GREEN,
        SS_AMBER
    } sched_state_t;

    function automatic logic [NPHASE-1:0] onehot3(input phase_t p);
        logic [NPHASE-1:0] oh;
        case (p)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Round-robin pick: first demanding phase after cur, wrapping back to cur itself.
    function automatic phase_t next_rr(input phase_t cur, input logic [NPHASE-1:0] dem);
        phase_t c1;
        phase_t c2;
        phase_t pick;
        c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (|(dem & onehot3(c1)))      pick = c1;
        else if (|(dem & onehot3(c2))) pick = c2;
        else                           pick = cur;
        return pick;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_PER_TICK clocks.
module tick_gen #(
    parameter int unsigned CLK_PER_TICK = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(CLK_PER_TICK - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Decoded from the counter register so CLK_PER_TICK=1 ticks every cycle.
    assign tick = (cnt == CW'(CLK_PER_TICK - 1));

endmodule

// File: rtl/junction_phase_scheduler.sv
// Demand-actuated round-robin green scheduler for a 3-phase junction with
// min/max green, gap extension, amber and all-red clearance.
module junction_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 1,
    parameter int unsigned TW           = 8,
    parameter int unsigned MIN_GREEN    = 4,
    parameter int unsigned MAX_GREEN    = 10,
    parameter int unsigned EXT          = 2,
    parameter int unsigned AMBER        = 2,
    parameter int unsigned ALL_RED      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPHASE-1:0] req,
    output logic [NPHASE-1:0] green,
    output logic [NPHASE-1:0] amber,
    output logic              all_red,
    output phase_t            cur_phase,
    output logic [NPHASE-1:0] demand
);

    logic              tick;
    sched_state_t      state;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     e;
    logic [TW-1:0]     g;

    logic [TW-1:0]     e_nx;
    logic [TW-1:0]     g_nx;
    logic              other;
    logic              green_exit;
    logic              red_ready;
    logic              amber_done;
    logic [NPHASE-1:0] req_eff;
    logic [NPHASE-1:0] demand_nx;
    phase_t            pick;

    tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Next-tick green timers and exit/expiry decisions.
    always_comb begin
        e_nx       = (e >= TW'(MAX_GREEN)) ? e : e + TW'(1);
        g_nx       = (|(req & onehot3(cur_phase))) ? TW'(EXT)
                   : ((g != '0) ? g - TW'(1) : '0);
        other      = |(demand & ~onehot3(cur_phase));
        green_exit = tick && other &&
                     ((e_nx >= TW'(MAX_GREEN)) ||
                      ((e_nx >= TW'(MIN_GREEN)) && (g_nx == '0)));
        red_ready  = (timer == '0) || (tick && (timer == TW'(1)));
        amber_done = tick && (timer <= TW'(1));
        pick       = next_rr(cur_phase, demand);
        // The served phase cannot re-request itself except on a max-out exit.
        req_eff    = req;
        if (state == SS_GREEN && !green_exit) begin
            req_eff = req & ~onehot3(cur_phase);
        end
        demand_nx  = demand | req_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SS_ALL_RED;
            timer     <= TW'(ALL_RED);
            e         <= '0;
            g         <= '0;
            green     <= '0;
            amber     <= '0;
            all_red   <= 1'b1;
            cur_phase <= 2'd2;
            demand    <= '0;
        end else begin
            demand <= demand_nx;
            case (state)
                SS_ALL_RED: begin
                    if (red_ready && (demand != '0)) begin
                        state     <= SS_GREEN;
                        cur_phase <= pick;
                        demand    <= demand_nx & ~onehot3(pick);
                        e         <= '0;
                        g         <= '0;
                        green     <= onehot3(pick);
                        all_red   <= 1'b0;
                    end else if (tick && (timer != '0)) begin
                        timer <= timer - TW'(1);
                    end
                end
                SS_GREEN: begin
                    if (tick) begin
                        e <= e_nx;
                        g <= g_nx;
                    end
                    if (green_exit) begin
                        state <= SS_AMBER;
                        timer <= TW'(AMBER);
                        green <= '0;
                        amber <= onehot3(cur_phase);
                    end
                end
                SS_AMBER: begin
                    if (amber_done) begin
                        state   <= SS_ALL_RED;
                        timer   <= TW'(ALL_RED);
                        amber   <= '0;
                        all_red <= 1'b1;
                    end else if (tick) begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state   <= SS_ALL_RED;
                    timer   <= TW'(ALL_RED);
                    green   <= '0;
                    amber   <= '0;
                    all_red <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed bench for junction_phase_scheduler at default timing, one tick per clock.
module tb_junction_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] green;
    logic [2:0] amber;
    logic       all_red;
    logic [1:0] cur_phase;
    logic [2:0] demand;
    logic [6:0] aspect;

    int n_checks = 0;
    int n_errors = 0;

    // Aspect encoding {green, amber, all_red}.
    localparam logic [6:0] A_RED = 7'b000_000_1;
    localparam logic [6:0] G0    = 7'b001_000_0;
    localparam logic [6:0] G1    = 7'b010_000_0;
    localparam logic [6:0] G2    = 7'b100_000_0;
    localparam logic [6:0] AM0   = 7'b000_001_0;
    localparam logic [6:0] AM1   = 7'b000_010_0;

    junction_phase_scheduler #(
        .CLK_PER_TICK (1),
        .TW           (8),
        .MIN_GREEN    (4),
        .MAX_GREEN    (10),
        .EXT          (2),
        .AMBER        (2),
        .ALL_RED      (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .green     (green),
        .amber     (amber),
        .all_red   (all_red),
        .cur_phase (cur_phase),
        .demand    (demand)
    );

    always #5 clk = ~clk;

    assign aspect = {green, amber, all_red};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the aspect for n consecutive cycles, advancing one clock after each.
    task automatic hold(input string tag, input logic [6:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 8'(aspect), 8'(exp));
            step();
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req = 3'b000;
        step();
        step();
        check({tag, "_aspect"}, 8'(aspect), 8'(A_RED));
        check({tag, "_demand"}, 8'(demand), 8'h0);
        check({tag, "_phase"},  8'(cur_phase), 8'h2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;

        // Idle after reset: rest in red.
        do_reset("rst0");
        hold("idle", A_RED, 50);
        check("idle_phase", 8'(cur_phase), 8'h2);

        // Single request from rest-in-red, then rest in green.
        do_reset("rst1");
        req = 3'b010;
        step();
        req = 3'b000;
        check("latch_demand", 8'(demand), 8'h2);
        check("latch_aspect", 8'(aspect), 8'(A_RED));
        step();
        check("grant_aspect", 8'(aspect), 8'(G1));
        check("grant_demand", 8'(demand), 8'h0);
        check("grant_phase",  8'(cur_phase), 8'h1);
        hold("rest_green", G1, 20);

        // All three phases request at once: round-robin 0,1,2.
        do_reset("rst2");
        req = 3'b111;
        step();
        req = 3'b000;
        check("rr_demand", 8'(demand), 8'h7);
        step();
        check("rr_demand0", 8'(demand), 8'h6);
        hold("rr_g0", G0, 4);
        hold("rr_a0", AM0, 2);
        hold("rr_r0", A_RED, 1);
        hold("rr_g1", G1, 4);
        hold("rr_a1", AM1, 2);
        hold("rr_r1", A_RED, 1);
        hold("rr_g2", G2, 10);
        check("rr_phase2", 8'(cur_phase), 8'h2);
        check("rr_demand_end", 8'(demand), 8'h0);

        // Max-out with req[0] held; grant-cycle request is cleared.
        do_reset("rst3");
        req = 3'b011;
        step();
        req = 3'b001;
        step();
        check("mo_grant_demand", 8'(demand), 8'h2);
        hold("mo_g0", G0, 10);
        check("mo_exit_aspect", 8'(aspect), 8'(AM0));
        check("mo_exit_demand", 8'(demand), 8'h3);
        req = 3'b000;
        hold("mo_a0", AM0, 2);
        hold("mo_r0", A_RED, 1);
        check("mo_phase1", 8'(cur_phase), 8'h1);
        hold("mo_g1", G1, 4);
        hold("mo_a1", AM1, 2);
        hold("mo_r1", A_RED, 1);
        check("mo_reserve", 8'(aspect), 8'(G0));
        check("mo_phase0", 8'(cur_phase), 8'h0);

        // Gap extension: req[0] during green cycles 1..5 gives 7 green cycles.
        do_reset("rst4");
        req = 3'b011;
        step();
        req = 3'b000;
        step();
        req = 3'b001;
        hold("gap_ext", G0, 5);
        req = 3'b000;
        hold("gap_tail", G0, 2);
        check("gap_exit", 8'(aspect), 8'(AM0));
        check("gap_demand", 8'(demand), 8'h2);

        // Reset during amber of phase 1 with demand 101.
        do_reset("rst5");
        req = 3'b011;
        step();
        req = 3'b000;
        step();
        hold("mr_g0", G0, 4);
        hold("mr_a0", AM0, 2);
        hold("mr_r0", A_RED, 1);
        req = 3'b101;
        hold("mr_g1a", G1, 1);
        req = 3'b000;
        hold("mr_g1b", G1, 3);
        check("mr_amber", 8'(aspect), 8'(AM1));
        check("mr_demand", 8'(demand), 8'h5);
        rst = 1'b1;
        step();
        check("mr_rst_aspect", 8'(aspect), 8'(A_RED));
        check("mr_rst_demand", 8'(demand), 8'h0);
        check("mr_rst_phase",  8'(cur_phase), 8'h2);
        rst = 1'b0;
        req = 3'b111;
        step();
        req = 3'b000;
        check("mr_post_demand", 8'(demand), 8'h7);
        step();
        hold("mr_post_g0", G0, 4);
        check("mr_post_amber", 8'(aspect), 8'(AM0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
